// File: rtl/multi_issue_ctrl.sv
// N-lane decode/control stage: decodes per-lane opcodes into control bundles and
// splits a fetch bundle over several cycles when memory ports or control flow demand it.
module multi_issue_ctrl #(
    parameter int LANES     = 2,
    parameter int MEM_PORTS = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [5*LANES-1:0]     opcode,
    input  logic [LANES-1:0]       in_valid,
    input  logic                   stall,
    input  logic                   flush,
    output logic [11*LANES-1:0]    ctrl_out,
    output logic [LANES-1:0]       out_valid,
    output logic                   bundle_hold
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    // Bit order: setx bex MemToReg MemWrite MemRead JAL JR JP branch ALUSrc regWrite
    function automatic logic [10:0] decode(input logic [4:0] op);
        logic [10:0] c;
        case (op)
            OP_R:    c = 11'h001;
            OP_J:    c = 11'h008;
            OP_BNE:  c = 11'h004;
            OP_JAL:  c = 11'h023;
            OP_JR:   c = 11'h010;
            OP_ADDI: c = 11'h003;
            OP_BLT:  c = 11'h004;
            OP_SW:   c = 11'h082;
            OP_LW:   c = 11'h143;
            OP_SETX: c = 11'h403;
            OP_BEX:  c = 11'h200;
            default: c = 11'h000;
        endcase
        return c;
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_cflow(input logic [4:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL) ||
               (op == OP_BNE) || (op == OP_BLT) || (op == OP_BEX);
    endfunction

    logic [LANES-1:0]    done;
    logic [LANES-1:0]    cand;
    logic [LANES-1:0]    group;
    logic [LANES-1:0]    rest;
    logic [11*LANES-1:0] ctrl_next;

    assign cand = in_valid & ~done;

    // Oldest-first group: stop before the lane that exceeds the memory ports,
    // and stop right after any control-flow lane.
    always_comb begin
        int  mem_cnt;
        logic stop;
        group   = '0;
        mem_cnt = 0;
        stop    = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!stop && cand[k]) begin
                if (is_mem(opcode[5*k +: 5]) && (mem_cnt >= MEM_PORTS)) begin
                    stop = 1'b1;
                end else begin
                    group[k] = 1'b1;
                    if (is_mem(opcode[5*k +: 5])) mem_cnt = mem_cnt + 1;
                    if (is_cflow(opcode[5*k +: 5])) stop = 1'b1;
                end
            end
        end
    end

    assign rest = cand & ~group;

    always_comb begin
        ctrl_next = '0;
        for (int k = 0; k < LANES; k++) begin
            if (group[k]) ctrl_next[11*k +: 11] = decode(opcode[5*k +: 5]);
        end
    end

    assign bundle_hold = flush ? 1'b0 : (stall | (|rest));

    // ID/EX latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_out  <= '0;
            out_valid <= '0;
            done      <= '0;
        end else if (flush) begin
            ctrl_out  <= '0;
            out_valid <= '0;
            done      <= '0;
        end else if (!stall) begin
            ctrl_out  <= ctrl_next;
            out_valid <= group;
            done      <= (|rest) ? (done | group) : '0;
        end
    end

endmodule
